// File: rtl/mdom_wvb_hdr_pkg.sv
// Shared constants for the waveform-buffer header serializer: bundle field
// offsets, word indices, FSM state type and the sample-count helper.
package mdom_wvb_hdr_pkg;

  localparam int HDR_W   = 104;
  localparam int WORD_W  = 16;
  localparam int NSAMP_W = 11;
  localparam int ADDR_W  = 10;
  localparam int IDX_W   = 4;

  localparam int HDR_NWORDS = 10;

  // Header bundle field offsets (LSB position) and widths
  localparam int LTC_LSB        = 0;
  localparam int START_LSB      = 49;
  localparam int STOP_LSB       = 59;
  localparam int TRIG_LSB       = 69;
  localparam int TRIG_W         = 2;
  localparam int CNST_BIT       = 71;
  localparam int PRECONF_LSB    = 72;
  localparam int PRECONF_W      = 5;
  localparam int SYNC_BIT       = 77;
  localparam int BSUM_LSB       = 78;
  localparam int BSUM_LEN_LSB   = 97;
  localparam int BSUM_LEN_W     = 3;
  localparam int BSUM_VALID_BIT = 100;
  localparam int COINC_BIT      = 101;
  localparam int PARTIAL_BIT    = 102;
  localparam int CONT_BIT       = 103;

  localparam logic [IDX_W-1:0] WI_0 = 4'd0;
  localparam logic [IDX_W-1:0] WI_1 = 4'd1;
  localparam logic [IDX_W-1:0] WI_2 = 4'd2;
  localparam logic [IDX_W-1:0] WI_3 = 4'd3;
  localparam logic [IDX_W-1:0] WI_4 = 4'd4;
  localparam logic [IDX_W-1:0] WI_5 = 4'd5;
  localparam logic [IDX_W-1:0] WI_6 = 4'd6;
  localparam logic [IDX_W-1:0] WI_7 = 4'd7;
  localparam logic [IDX_W-1:0] WI_8 = 4'd8;
  localparam logic [IDX_W-1:0] WI_9 = 4'd9;
  localparam logic [IDX_W-1:0] WI_LAST = IDX_W'(HDR_NWORDS - 1);

  localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hD;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } hdr_state_e;

  // Ring-buffer span: the 10-bit difference wraps naturally, so stop==start-1 yields 1024
  function automatic logic [NSAMP_W-1:0] calc_nsamp(input logic [ADDR_W-1:0] start_addr,
                                                   input logic [ADDR_W-1:0] stop_addr);
    logic [ADDR_W-1:0] diff;
    diff = stop_addr - start_addr;
    return {1'b0, diff} + 11'd1;
  endfunction

endpackage

// File: rtl/mdom_wvb_hdr_serializer_if.sv
// Header word stream toward the readout arbiter (valid/ready with packet framing).
interface mdom_wvb_hdr_serializer_if;
  import mdom_wvb_hdr_pkg::*;

  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_sop;
  logic              dout_eop;

  modport master (output dout, output dout_valid, output dout_sop, output dout_eop,
                  input  dout_ready);
  modport slave  (input  dout, input  dout_valid, input  dout_sop, input  dout_eop,
                  output dout_ready);
endinterface

// File: rtl/mdom_wvb_hdr_word_mux.sv
// Selects one 16-bit header word from the latched bundle and sample count.
module mdom_wvb_hdr_word_mux
  import mdom_wvb_hdr_pkg::*;
#(
  parameter logic [4:0] CHAN_ID   = 5'd0,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic [HDR_W-1:0]   hdr,
  input  logic [NSAMP_W-1:0] nsamp,
  input  logic [IDX_W-1:0]   idx,
  output logic [WORD_W-1:0]  word
);

  // Word map, MSB first
  always_comb begin
    word = 16'h0000;
    case (idx)
      WI_0: word = {HDR_MAGIC, CHAN_ID, hdr[TRIG_LSB +: TRIG_W], hdr[CNST_BIT], hdr[COINC_BIT],
                    hdr[PARTIAL_BIT], hdr[CONT_BIT], hdr[SYNC_BIT]};
      WI_1: word = {hdr[PRECONF_LSB +: PRECONF_W], hdr[BSUM_LEN_LSB +: BSUM_LEN_W],
                    hdr[BSUM_VALID_BIT], 6'b000000, hdr[LTC_LSB + 48]};
      WI_2: word = hdr[LTC_LSB + 32 +: 16];
      WI_3: word = hdr[LTC_LSB + 16 +: 16];
      WI_4: word = hdr[LTC_LSB +: 16];
      WI_5: word = {6'b000000, hdr[START_LSB +: ADDR_W]};
      WI_6: word = {6'b000000, hdr[STOP_LSB +: ADDR_W]};
      WI_7: word = {5'b00000, nsamp};
      WI_8: word = {13'b0000000000000, hdr[BSUM_LSB + 16 +: 3]};
      WI_9: word = hdr[BSUM_LSB +: 16];
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/mdom_wvb_hdr_serializer.sv
// Pops one header bundle per waveform from the show-ahead FIFO, streams it as ten
// 16-bit words and hands start address / sample count to the sample reader.
module mdom_wvb_hdr_serializer
  import mdom_wvb_hdr_pkg::*;
#(
  parameter logic [4:0] CHAN_ID   = 5'd0,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [HDR_W-1:0]           hdr_data,
  input  logic                       hdr_empty,
  output logic                       hdr_rdreq,
  mdom_wvb_hdr_serializer_if.master  dout_if,
  output logic                       busy,
  output logic [ADDR_W-1:0]          wfm_start_addr,
  output logic [NSAMP_W-1:0]         wfm_nsamp,
  output logic                       wfm_req
);

  hdr_state_e         state_r;
  hdr_state_e         state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_s;
  logic               pop_s;
  logic               last_s;
  logic [HDR_W-1:0]   hdr_r;
  logic [NSAMP_W-1:0] nsamp_r;
  logic [ADDR_W-1:0]  wfm_start_r;
  logic [NSAMP_W-1:0] wfm_nsamp_r;
  logic               wfm_req_r;
  logic [WORD_W-1:0]  word_s;

  // Next-state, word index and pop/completion strobes
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    pop_s   = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && !hdr_empty) begin
          pop_s   = 1'b1;
          idx_s   = WI_0;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (dout_if.dout_ready) begin
          if (idx_r == WI_LAST) begin
            last_s  = 1'b1;
            idx_s   = WI_0;
            state_s = IDLE;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = WI_0;
      end
    endcase
  end

  // FSM state and word index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= WI_0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Header capture; nsamp is resolved here so word 7 costs no extra cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_r   <= {HDR_W{1'b0}};
      nsamp_r <= 11'd0;
    end else if (pop_s) begin
      hdr_r   <= hdr_data;
      nsamp_r <= calc_nsamp(hdr_data[START_LSB +: ADDR_W], hdr_data[STOP_LSB +: ADDR_W]);
    end
  end

  // Sample-reader handoff, updated together with the request pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wfm_req_r   <= 1'b0;
      wfm_start_r <= 10'd0;
      wfm_nsamp_r <= 11'd0;
    end else begin
      wfm_req_r <= last_s;
      if (last_s) begin
        wfm_start_r <= hdr_r[START_LSB +: ADDR_W];
        wfm_nsamp_r <= nsamp_r;
      end
    end
  end

  mdom_wvb_hdr_word_mux #(
    .CHAN_ID   (CHAN_ID),
    .HDR_MAGIC (HDR_MAGIC)
  ) u_word_mux (
    .hdr   (hdr_r),
    .nsamp (nsamp_r),
    .idx   (idx_r),
    .word  (word_s)
  );

  assign hdr_rdreq          = pop_s;
  assign busy               = (state_r != IDLE);
  assign dout_if.dout       = word_s;
  assign dout_if.dout_valid = (state_r == SEND);
  assign dout_if.dout_sop   = (state_r == SEND) && (idx_r == WI_0);
  assign dout_if.dout_eop   = (state_r == SEND) && (idx_r == WI_LAST);
  assign wfm_req            = wfm_req_r;
  assign wfm_start_addr     = wfm_start_r;
  assign wfm_nsamp          = wfm_nsamp_r;

endmodule

// File: tb/tb_mdom_wvb_hdr_serializer.sv
// Scoreboard bench for the header serializer: a FIFO model feeds bundles, expected
// words and handoff values are queued at push time and checked as the DUT emits them.
module tb_mdom_wvb_hdr_serializer;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [103:0] hdr_data;
  logic         hdr_empty;
  logic         hdr_rdreq;
  logic         busy;
  logic [9:0]   wfm_start_addr;
  logic [10:0]  wfm_nsamp;
  logic         wfm_req;

  mdom_wvb_hdr_serializer_if bus ();

  mdom_wvb_hdr_serializer #(
    .CHAN_ID   (5'd3),
    .HDR_MAGIC (4'hD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .hdr_data       (hdr_data),
    .hdr_empty      (hdr_empty),
    .hdr_rdreq      (hdr_rdreq),
    .dout_if        (bus.master),
    .busy           (busy),
    .wfm_start_addr (wfm_start_addr),
    .wfm_nsamp      (wfm_nsamp),
    .wfm_req        (wfm_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_cnt = 0;
  int word_cnt = 0;
  int wfm_cnt = 0;
  int word_pos = 0;
  int gap = 0;
  bit had_eop = 1'b0;
  bit chk_gap = 1'b0;
  bit rdy_rand = 1'b0;
  bit rd_pend = 1'b0;

  logic [103:0] fifo[$];
  logic [17:0]  exp_q[$];   // {sop, eop, word}
  logic [20:0]  wfm_q[$];   // {start_addr, nsamp}

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    hdr_empty = (fifo.size() == 0);
    hdr_data  = (fifo.size() == 0) ? 104'd0 : fifo[0];
  endtask

  function automatic logic [10:0] nsamp_model(input logic [9:0] sa, input logic [9:0] so);
    logic [9:0] d;
    d = so - sa;
    return {1'b0, d} + 11'd1;
  endfunction

  function automatic logic [103:0] mk_hdr(input logic [48:0] ltc, input logic [9:0] sa,
                                          input logic [9:0] so, input logic [1:0] trig,
                                          input logic [18:0] bsum, input logic [4:0] pre,
                                          input logic [2:0] len, input logic [5:0] flags);
    logic [103:0] h;
    h = 104'd0;
    h[48:0]   = ltc;
    h[58:49]  = sa;
    h[68:59]  = so;
    h[70:69]  = trig;
    h[71]     = flags[0];
    h[76:72]  = pre;
    h[77]     = flags[1];
    h[96:78]  = bsum;
    h[99:97]  = len;
    h[100]    = flags[2];
    h[101]    = flags[3];
    h[102]    = flags[4];
    h[103]    = flags[5];
    return h;
  endfunction

  function automatic logic [15:0] exp_word(input logic [103:0] h, input int i,
                                           input logic [10:0] ns);
    case (i)
      0: return {4'hD, 5'd3, h[70:69], h[71], h[101], h[102], h[103], h[77]};
      1: return {h[76:72], h[99:97], h[100], 6'b000000, h[48]};
      2: return h[47:32];
      3: return h[31:16];
      4: return h[15:0];
      5: return {6'b000000, h[58:49]};
      6: return {6'b000000, h[68:59]};
      7: return {5'b00000, ns};
      8: return {13'd0, h[96:94]};
      default: return h[93:78];
    endcase
  endfunction

  function automatic logic [103:0] rand_hdr();
    logic [63:0] r64;
    logic [31:0] r32;
    r64 = {$urandom(), $urandom()};
    r32 = $urandom();
    return mk_hdr(r64[48:0], r32[9:0], r32[19:10], r32[21:20], r64[63:45],
                  r32[26:22], r32[29:27], 6'($urandom_range(0, 63)));
  endfunction

  task automatic push_hdr(input logic [103:0] h, input logic [10:0] ns);
    fifo.push_back(h);
    fifo_refresh();
    for (int i = 0; i < 10; i++)
      exp_q.push_back({(i == 0), (i == 9), exp_word(h, i, ns)});
    wfm_q.push_back({h[58:49], ns});
  endtask

  task automatic push_rand();
    logic [103:0] h;
    h = rand_hdr();
    push_hdr(h, nsamp_model(h[58:49], h[68:59]));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rdy_rand) bus.dout_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_wfm(input int target, input int budget);
    int n;
    n = 0;
    while (wfm_cnt < target && n < budget) begin
      cyc(1);
      n++;
    end
    if (wfm_cnt < target) chk("timeout_wfm", wfm_cnt, target);
  endtask

  task automatic wait_pos(input int pos, input int budget);
    int n;
    n = 0;
    while (word_pos != pos && n < budget) begin
      cyc(1);
      n++;
    end
    if (word_pos != pos) chk("timeout_pos", word_pos, pos);
  endtask

  // FIFO model: pop observed at the previous falling edge takes effect after the clock edge
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_pend) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      rd_pend = 1'b0;
    end
    fifo_refresh();
  end

  // Output monitor and scoreboard, sampled on the falling edge
  initial begin : mon
    logic [17:0] e;
    logic [20:0] w;
    forever begin
      @(negedge clk);
      rd_pend = hdr_rdreq && rst_n;
      if (rst_n) begin
        if (hdr_rdreq) rd_cnt++;
        if (wfm_req) begin
          wfm_cnt++;
          if (wfm_q.size() == 0) chk("wfm_req_unexpected", 1, 0);
          else begin
            w = wfm_q.pop_front();
            chk("wfm_start", wfm_start_addr, w[20:11]);
            chk("wfm_nsamp", wfm_nsamp, w[10:0]);
          end
        end
        if (bus.dout_valid) begin
          if (chk_gap && had_eop) begin
            chk("idle_gap", gap, 1);
            had_eop = 1'b0;
          end
          if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
          else begin
            e = exp_q[0];
            if (bus.dout_ready) begin
              void'(exp_q.pop_front());
              word_cnt++;
              word_pos++;
              chk("word", bus.dout, e[15:0]);
              chk("sop", bus.dout_sop, e[17]);
              chk("eop", bus.dout_eop, e[16]);
              if (e[16]) begin
                word_pos = 0;
                had_eop  = 1'b1;
                gap      = 0;
              end
            end else begin
              chk("stall_hold", {bus.dout_sop, bus.dout_eop, bus.dout}, e);
            end
          end
        end else if (had_eop) begin
          gap++;
        end
      end
    end
  end

  initial begin
    int r0, w0, f0;
    logic [9:0]  sa_t [4] = '{10'd1020, 10'd5, 10'd6, 10'd0};
    logic [9:0]  so_t [4] = '{10'd3, 10'd5, 10'd5, 10'd1023};
    logic [10:0] ns_t [4] = '{11'd8, 11'd1, 11'd1024, 11'd1024};

    rst_n = 1'b0;
    en = 1'b0;
    bus.dout_ready = 1'b0;
    fifo_refresh();
    cyc(3);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_sop_eop", {bus.dout_sop, bus.dout_eop}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdreq", hdr_rdreq, 0);
    chk("rst_wfm", {wfm_req, wfm_start_addr, wfm_nsamp}, 0);
    rst_n = 1'b1;
    cyc(2);

    // Single entry with all ready
    bus.dout_ready = 1'b1;
    push_hdr(mk_hdr(49'h1_2345_6789_ABCD, 10'd10, 10'd19, 2'd2, 19'h5_1234, 5'd0, 3'd0, 6'd0),
             11'd10);
    en = 1'b1;
    wait_wfm(1, 100);
    chk("t1_nsamp", wfm_nsamp, 11'd10);
    chk("t1_start", wfm_start_addr, 10'd10);
    en = 1'b0;
    cyc(3);

    // Random backpressure
    w0 = word_cnt;
    f0 = wfm_cnt;
    rdy_rand = 1'b1;
    push_rand();
    en = 1'b1;
    wait_wfm(f0 + 1, 400);
    chk("t2_words", word_cnt - w0, 10);
    rdy_rand = 1'b0;
    bus.dout_ready = 1'b1;
    en = 1'b0;
    cyc(3);

    // Sample-count boundaries including ring wrap
    f0 = wfm_cnt;
    for (int i = 0; i < 4; i++)
      push_hdr(mk_hdr(49'(64'h1000 + i), sa_t[i], so_t[i], 2'd1, 19'h7_0F0F, 5'd9, 3'd5, 6'h15),
               ns_t[i]);
    en = 1'b1;
    wait_wfm(f0 + 4, 300);
    en = 1'b0;
    cyc(3);

    // Three back-to-back entries, one idle cycle between headers
    r0 = rd_cnt;
    w0 = word_cnt;
    f0 = wfm_cnt;
    had_eop = 1'b0;
    chk_gap = 1'b1;
    for (int i = 0; i < 3; i++) push_rand();
    en = 1'b1;
    wait_wfm(f0 + 3, 300);
    cyc(3);
    chk_gap = 1'b0;
    chk("t4_rdreq", rd_cnt - r0, 3);
    chk("t4_words", word_cnt - w0, 30);
    chk("t4_wfm", wfm_cnt - f0, 3);
    en = 1'b0;
    cyc(2);

    // en dropped mid-header
    r0 = rd_cnt;
    f0 = wfm_cnt;
    push_rand();
    push_rand();
    en = 1'b1;
    wait_pos(4, 100);
    en = 1'b0;
    wait_wfm(f0 + 1, 100);
    cyc(10);
    chk("t5_rdreq_held", rd_cnt - r0, 1);
    chk("t5_busy", busy, 0);
    chk("t5_fifo_left", fifo.size(), 1);
    en = 1'b1;
    wait_wfm(f0 + 2, 100);
    chk("t5_rdreq_resume", rd_cnt - r0, 2);
    en = 1'b0;
    cyc(3);

    // Reset at word 5: partial header dropped, next entry restarts at W0
    f0 = wfm_cnt;
    push_rand();
    push_rand();
    en = 1'b1;
    wait_pos(5, 100);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("t6_valid_drop", bus.dout_valid, 0);
    chk("t6_busy_drop", busy, 0);
    while (exp_q.size() > 0) begin
      if (exp_q.pop_front() & 18'h10000) break;
    end
    void'(wfm_q.pop_front());
    word_pos = 0;
    cyc(3);
    chk("t6_no_wfm_req", wfm_cnt - f0, 0);
    rst_n = 1'b1;
    en = 1'b1;
    wait_wfm(f0 + 1, 100);
    en = 1'b0;
    cyc(4);
    chk("t6_wfm_after", wfm_cnt - f0, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("wfm_drained", wfm_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
